tl_cmd_sequencer: RTL and testbench
===================================

Name: tl_cmd_sequencer

Overview:
- Command initiator for the traffic-light controller's command bus (cmd_type/cmd_valid/cmd_data).
- Accepts one high-level request per valid/ready handshake: on, off, blink-yellow, or reconfigure periods.
- Expands each request into the legal single-cycle command sequence on the controller's bus.
- Reconfiguration is always wrapped as 2 (no-transition), then period writes 3/4/5, then 0 (on). The controller only accepts period writes in no-transition mode.

Parameters:
CMD_GAP_CYCLES, 1, idle cycles inserted between consecutive commands of one sequence; legal range 0..255
DATA_W, 16, command data / period width
CMD_W, 3, command type width

Ports:
clk_i  in  1  clock
srst_n_i  in  1  synchronous reset, active-low
req_valid_i  in  1  request valid
req_ready_o  out  1  request ready; high only in IDLE
req_op_i  in  2  0=ON, 1=OFF, 2=BLINK, 3=CONFIG
req_mask_i  in  3  CONFIG only: bit0 green, bit1 red, bit2 yellow write enables
req_green_i  in  DATA_W  green period
req_red_i  in  DATA_W  red period
req_yellow_i  in  DATA_W  yellow period
cmd_type_o  out  CMD_W  command type to controller
cmd_valid_o  out  1  command strobe, one cycle per command
cmd_data_o  out  DATA_W  command payload
busy_o  out  1  sequence in progress
done_o  out  1  one-cycle pulse coincident with last command of a sequence
err_o  out  1  one-cycle pulse on rejected request (optional feature only)

Behaviour:
- Interface: one clock clk_i; reset srst_n_i is synchronous, active-low.
- Reset values: req_ready_o=1, all other outputs 0, FSM=IDLE, gap counter 0.
- Reset mid-sequence: abort immediately. No further commands are issued and the captured request is discarded.
- Handshake:
  - Accept on the cycle where req_valid_i && req_ready_o.
  - All req_* fields are captured into registers on accept.
  - Inputs are ignored while busy.
- Latency: the first command has cmd_valid_o=1 in the cycle after accept.
- Command spacing: within a sequence, exactly CMD_GAP_CYCLES cycles with cmd_valid_o=0 separate two commands. CMD_GAP_CYCLES=0 gives back-to-back commands.
- When cmd_valid_o=0, cmd_type_o and cmd_data_o are 0.
- cmd_data_o is 0 for types 0, 1 and 2.
- Sequences:
  - ON: 0.
  - OFF: 1.
  - BLINK: 2.
  - CONFIG: 2, then 3(green) if mask[0], 4(red) if mask[1], 5(yellow) if mask[2], in that fixed order, then 0.
  - CONFIG with mask=000: 2, then 0.
- FSM states: IDLE, ISSUE, GAP. A step index selects the current command from the captured request.
  - IDLE -> ISSUE on accept.
  - ISSUE -> GAP if more commands remain and CMD_GAP_CYCLES>0.
  - ISSUE -> ISSUE (next step) if more commands remain and CMD_GAP_CYCLES=0.
  - ISSUE -> IDLE after the last command.
  - GAP -> ISSUE when the gap counter reaches CMD_GAP_CYCLES-1. The counter clears on entry to GAP.
  - Masked-off steps are skipped without consuming gap cycles.
- busy_o equals !req_ready_o. It is high from the cycle after accept through the cycle of the last command.
- done_o is high in the same cycle as the last cmd_valid_o.
- req_ready_o returns high in the cycle after the last command. A new request can be accepted then, and its first command follows one cycle later.
- A period value of 0 is forwarded unchanged, unless the optional feature is enabled.

Optional Feature:
- Macro: TL_SEQ_ZERO_GUARD_EN.
- Defined, accept-time check: a CONFIG request with any enabled period equal to 0 is accepted but rejected.
  - err_o pulses one cycle after accept.
  - No commands are issued.
  - req_ready_o stays high throughout.
- Not defined: err_o is tied 0 and zero periods are forwarded unchanged.

Test Plan:
- Reset release with no requests -> req_ready_o=1, cmd_valid_o=0, busy_o=0 indefinitely. Assert srst_n_i=0 during a CONFIG sequence -> no further cmd_valid_o pulses; ready=1 the cycle after reset is released.
- CONFIG, mask=111, G=20, R=30, Y=7, CMD_GAP_CYCLES=1, accepted at cycle t:
  - Commands at t+1 (2,0), t+3 (3,20), t+5 (4,30), t+7 (5,7), t+9 (0,0).
  - done_o at t+9, ready at t+10.
- CONFIG, mask=010, R=100, CMD_GAP_CYCLES=0 -> commands (2,0), (4,100), (0,0) on three consecutive cycles; green and yellow steps skipped.
- OFF then ON, req_valid_i held high continuously -> cmd 1 at t+1 with done_o; ON accepted at t+2; cmd 0 at t+3.
- BLINK with req_valid_i pulsed while busy from a prior CONFIG -> BLINK not accepted until ready returns; exactly one cmd 2 is emitted afterward.
- TL_SEQ_ZERO_GUARD_EN defined, CONFIG mask=001, G=0 -> err_o pulse at t+1, zero cmd_valid_o pulses. Without the macro -> sequence (2,0), (3,0), (0,0) issued.

Source files
------------

// File: rtl/tl_cmd_sequencer.sv
// Traffic-light command-bus sequencer: expands on/off/blink/config requests into controller commands.
// Optional build macro TL_SEQ_ZERO_GUARD_EN rejects CONFIG requests carrying an enabled zero period.
module tl_cmd_sequencer #(
    parameter int unsigned CMD_GAP_CYCLES = 1,
    parameter int unsigned DATA_W         = 16,
    parameter int unsigned CMD_W          = 3
) (
    input  logic              clk_i,
    input  logic              srst_n_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [1:0]        req_op_i,
    input  logic [2:0]        req_mask_i,
    input  logic [DATA_W-1:0] req_green_i,
    input  logic [DATA_W-1:0] req_red_i,
    input  logic [DATA_W-1:0] req_yellow_i,
    output logic [CMD_W-1:0]  cmd_type_o,
    output logic              cmd_valid_o,
    output logic [DATA_W-1:0] cmd_data_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP} state_t;

    localparam logic [1:0] OP_ON     = 2'd0;
    localparam logic [1:0] OP_OFF    = 2'd1;
    localparam logic [1:0] OP_CONFIG = 2'd3;
    localparam logic [2:0] STEP_ON   = 3'd4;
    localparam logic [7:0] GAP_LAST  = 8'((CMD_GAP_CYCLES > 0) ? CMD_GAP_CYCLES - 1 : 0);

    state_t            r_state;
    logic              r_ready;
    logic              r_busy;
    logic              r_cmd_valid;
    logic [CMD_W-1:0]  r_cmd_type;
    logic [DATA_W-1:0] r_cmd_data;
    logic              r_done;
    logic [7:0]        r_gap_cnt;
    logic [2:0]        r_step;
    logic [1:0]        r_op;
    logic [2:0]        r_mask;
    logic [DATA_W-1:0] r_green;
    logic [DATA_W-1:0] r_red;
    logic [DATA_W-1:0] r_yellow;

    logic              w_accept;
    logic              w_last;
    logic [2:0]        w_next_step;

    // Steps: 0 = first command (type from op), 1..3 = green/red/yellow writes, 4 = final ON.
    function automatic logic [2:0] f_next(input logic [2:0] mask, input logic [2:0] step);
        logic [2:0] n;
        n = STEP_ON;
        if (step < 3'd1 && mask[0])      n = 3'd1;
        else if (step < 3'd2 && mask[1]) n = 3'd2;
        else if (step < 3'd3 && mask[2]) n = 3'd3;
        return n;
    endfunction

    function automatic logic f_last(input logic [1:0] op, input logic [2:0] step);
        return (op != OP_CONFIG) || (step == STEP_ON);
    endfunction

    function automatic logic [CMD_W-1:0] f_type(input logic [1:0] op, input logic [2:0] step);
        logic [CMD_W-1:0] t;
        t = '0;
        if (step == 3'd0) begin
            if (op == OP_ON)       t = CMD_W'(0);
            else if (op == OP_OFF) t = CMD_W'(1);
            else                   t = CMD_W'(2);
        end else if (step != STEP_ON) begin
            t = CMD_W'(step + 3'd2);
        end
        return t;
    endfunction

    function automatic logic [DATA_W-1:0] f_data(input logic [2:0] step);
        logic [DATA_W-1:0] d;
        d = '0;
        case (step)
            3'd1:    d = r_green;
            3'd2:    d = r_red;
            3'd3:    d = r_yellow;
            default: d = '0;
        endcase
        return d;
    endfunction

    assign w_accept    = req_valid_i && r_ready;
    assign w_last      = f_last(r_op, r_step);
    assign w_next_step = f_next(r_mask, r_step);

`ifdef TL_SEQ_ZERO_GUARD_EN
    logic r_err;
    logic w_reject;
    assign w_reject = (req_op_i == OP_CONFIG) &&
                      ((req_mask_i[0] && req_green_i  == '0) ||
                       (req_mask_i[1] && req_red_i    == '0) ||
                       (req_mask_i[2] && req_yellow_i == '0));
    assign err_o = r_err;
`else
    assign err_o = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            r_state     <= S_IDLE;
            r_ready     <= 1'b1;
            r_busy      <= 1'b0;
            r_cmd_valid <= 1'b0;
            r_cmd_type  <= '0;
            r_cmd_data  <= '0;
            r_done      <= 1'b0;
            r_gap_cnt   <= '0;
            r_step      <= '0;
            r_op        <= '0;
            r_mask      <= '0;
            r_green     <= '0;
            r_red       <= '0;
            r_yellow    <= '0;
`ifdef TL_SEQ_ZERO_GUARD_EN
            r_err       <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
`ifdef TL_SEQ_ZERO_GUARD_EN
            r_err  <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
`ifdef TL_SEQ_ZERO_GUARD_EN
                        if (w_reject) begin
                            r_err <= 1'b1;
                        end else
`endif
                        begin
                            r_op        <= req_op_i;
                            r_mask      <= req_mask_i;
                            r_green     <= req_green_i;
                            r_red       <= req_red_i;
                            r_yellow    <= req_yellow_i;
                            r_step      <= 3'd0;
                            r_cmd_valid <= 1'b1;
                            r_cmd_type  <= f_type(req_op_i, 3'd0);
                            r_cmd_data  <= '0;
                            r_done      <= (req_op_i != OP_CONFIG);
                            r_ready     <= 1'b0;
                            r_busy      <= 1'b1;
                            r_state     <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (w_last) begin
                        r_cmd_valid <= 1'b0;
                        r_cmd_type  <= '0;
                        r_cmd_data  <= '0;
                        r_ready     <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end else if (CMD_GAP_CYCLES == 0) begin
                        r_step      <= w_next_step;
                        r_cmd_valid <= 1'b1;
                        r_cmd_type  <= f_type(r_op, w_next_step);
                        r_cmd_data  <= f_data(w_next_step);
                        r_done      <= f_last(r_op, w_next_step);
                    end else begin
                        // Step advances on GAP entry so skipped mask bits cost no gap cycles.
                        r_step      <= w_next_step;
                        r_cmd_valid <= 1'b0;
                        r_cmd_type  <= '0;
                        r_cmd_data  <= '0;
                        r_gap_cnt   <= '0;
                        r_state     <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt == GAP_LAST) begin
                        r_cmd_valid <= 1'b1;
                        r_cmd_type  <= f_type(r_op, r_step);
                        r_cmd_data  <= f_data(r_step);
                        r_done      <= w_last;
                        r_state     <= S_ISSUE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 8'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready_o = r_ready;
    assign busy_o      = r_busy;
    assign cmd_valid_o = r_cmd_valid;
    assign cmd_type_o  = r_cmd_type;
    assign cmd_data_o  = r_cmd_data;
    assign done_o      = r_done;

endmodule

// File: tb/tb_tl_cmd_sequencer.sv
// Bench for tl_cmd_sequencer: one instance with a 1-cycle command gap, one back-to-back,
// compared cycle by cycle against a command-list model of each request.
module tb_tl_cmd_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        srst_n;
    logic        va, vb;
    logic [1:0]  op;
    logic [2:0]  mask;
    logic [15:0] g, r, y;

    logic        rdy0, bsy0, vld0, dn0, er0;
    logic [2:0]  ty0;
    logic [15:0] dt0;
    logic        rdy1, bsy1, vld1, dn1, er1;
    logic [2:0]  ty1;
    logic [15:0] dt1;

    tl_cmd_sequencer #(.CMD_GAP_CYCLES(1), .DATA_W(16), .CMD_W(3)) u_gap1 (
        .clk_i(clk), .srst_n_i(srst_n), .req_valid_i(va), .req_ready_o(rdy0),
        .req_op_i(op), .req_mask_i(mask), .req_green_i(g), .req_red_i(r), .req_yellow_i(y),
        .cmd_type_o(ty0), .cmd_valid_o(vld0), .cmd_data_o(dt0),
        .busy_o(bsy0), .done_o(dn0), .err_o(er0));

    tl_cmd_sequencer #(.CMD_GAP_CYCLES(0), .DATA_W(16), .CMD_W(3)) u_gap0 (
        .clk_i(clk), .srst_n_i(srst_n), .req_valid_i(vb), .req_ready_o(rdy1),
        .req_op_i(op), .req_mask_i(mask), .req_green_i(g), .req_red_i(r), .req_yellow_i(y),
        .cmd_type_o(ty1), .cmd_valid_o(vld1), .cmd_data_o(dt1),
        .busy_o(bsy1), .done_o(dn1), .err_o(er1));

    bit          sel = 1'b0;
    logic        o_rdy, o_bsy, o_vld, o_dn, o_er;
    logic [2:0]  o_ty;
    logic [15:0] o_dt;

    always_comb begin
        o_rdy = sel ? rdy1 : rdy0;
        o_bsy = sel ? bsy1 : bsy0;
        o_vld = sel ? vld1 : vld0;
        o_dn  = sel ? dn1  : dn0;
        o_er  = sel ? er1  : er0;
        o_ty  = sel ? ty1  : ty0;
        o_dt  = sel ? dt1  : dt0;
    end

    int checks = 0;
    int errors = 0;

    logic [2:0]  et[$];
    logic [15:0] ed[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model: the ordered list of (type,data) commands a request must produce.
    function automatic bit build(input logic [1:0] o, input logic [2:0] m,
                                 input logic [15:0] gg, input logic [15:0] rr, input logic [15:0] yy);
        bit rej;
        et.delete();
        ed.delete();
        rej = 1'b0;
`ifdef TL_SEQ_ZERO_GUARD_EN
        rej = (o == 2'd3) && ((m[0] && gg == 0) || (m[1] && rr == 0) || (m[2] && yy == 0));
`endif
        if (o != 2'd3) begin
            et.push_back(o == 2'd0 ? 3'd0 : (o == 2'd1 ? 3'd1 : 3'd2));
            ed.push_back(16'd0);
        end else begin
            et.push_back(3'd2); ed.push_back(16'd0);
            if (m[0]) begin et.push_back(3'd3); ed.push_back(gg); end
            if (m[1]) begin et.push_back(3'd4); ed.push_back(rr); end
            if (m[2]) begin et.push_back(3'd5); ed.push_back(yy); end
            et.push_back(3'd0); ed.push_back(16'd0);
        end
        return rej;
    endfunction

    task automatic set_valid(input bit s, input logic v);
        if (s) vb = v; else va = v;
    endtask

    task automatic idle_check(input string tag);
        chk({tag, " ready"}, o_rdy, 1);
        chk({tag, " valid"}, o_vld, 0);
        chk({tag, " busy"},  o_bsy, 0);
        chk({tag, " done"},  o_dn,  0);
        chk({tag, " err"},   o_er,  0);
    endtask

    // Issue one request on instance s and check every cycle until ready returns.
    // pulse_at > 0 raises a BLINK request for one cycle while the sequence is busy.
    task automatic run(input bit s, input logic [1:0] o, input logic [2:0] m,
                       input logic [15:0] gg, input logic [15:0] rr, input logic [15:0] yy,
                       input int pulse_at);
        int gap, n, L, k, idx;
        bit rej, is_cmd;
        sel = s;
        gap = s ? 0 : 1;
        @(posedge clk); #1;
        op = o; mask = m; g = gg; r = rr; y = yy;
        set_valid(s, 1'b1);
        @(negedge clk);
        chk("ready before accept", o_rdy, 1);
        @(posedge clk); #1;
        set_valid(s, 1'b0);
        op = 2'($urandom); mask = 3'($urandom); g = 16'($urandom); r = 16'($urandom); y = 16'($urandom);
        rej = build(o, m, gg, rr, yy);
        n = et.size();
        if (rej) begin
            @(negedge clk);
            chk("reject err", o_er, 1);
            chk("reject valid", o_vld, 0);
            chk("reject ready", o_rdy, 1);
            @(posedge clk); @(negedge clk);
            chk("reject err clear", o_er, 0);
            chk("reject no cmd", o_vld, 0);
            return;
        end
        L = (n - 1) * (gap + 1) + 1;
        for (int c = 1; c <= L + 1; c++) begin
            if (c > 1) begin
                @(posedge clk); #1;
                if (pulse_at > 0) begin
                    if (c == pulse_at) op = 2'd2;
                    set_valid(s, c == pulse_at);
                end
            end
            @(negedge clk);
            k = c - 1;
            is_cmd = (c <= L) && (k % (gap + 1) == 0);
            idx = k / (gap + 1);
            chk($sformatf("valid c%0d", c), o_vld, is_cmd);
            chk($sformatf("type c%0d", c),  o_ty,  is_cmd ? et[idx] : 3'd0);
            chk($sformatf("data c%0d", c),  o_dt,  is_cmd ? ed[idx] : 16'd0);
            chk($sformatf("done c%0d", c),  o_dn,  is_cmd && (idx == n - 1));
            chk($sformatf("ready c%0d", c), o_rdy, c == L + 1);
            chk($sformatf("busy c%0d", c),  o_bsy, c <= L);
            chk($sformatf("err c%0d", c),   o_er,  0);
        end
    endtask

    initial begin
        srst_n = 1'b0; va = 1'b0; vb = 1'b0;
        op = '0; mask = '0; g = '0; r = '0; y = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        sel = 0; idle_check("in reset gap1");
        sel = 1; idle_check("in reset gap0");
        @(posedge clk); #1 srst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            sel = 0; idle_check("idle gap1");
            sel = 1; idle_check("idle gap0");
        end

        run(0, 2'd3, 3'b111, 16'd20, 16'd30, 16'd7, 0);
        run(1, 2'd3, 3'b010, 16'd5, 16'd100, 16'd9, 0);
        run(0, 2'd3, 3'b000, 16'd1, 16'd2, 16'd3, 0);
        run(0, 2'd3, 3'b001, 16'd0, 16'd4, 16'd4, 0);
        run(1, 2'd3, 3'b001, 16'd0, 16'd4, 16'd4, 0);

        // OFF then ON with valid held high throughout.
        sel = 0;
        @(posedge clk); #1 op = 2'd1; va = 1'b1;
        @(posedge clk); #1 op = 2'd0;
        @(negedge clk);
        chk("off valid", o_vld, 1); chk("off type", o_ty, 1);
        chk("off done", o_dn, 1);   chk("off ready", o_rdy, 0);
        @(negedge clk);
        chk("off->on ready", o_rdy, 1); chk("off->on gap valid", o_vld, 0);
        @(posedge clk); #1 va = 1'b0;
        @(negedge clk);
        chk("on valid", o_vld, 1); chk("on type", o_ty, 0); chk("on done", o_dn, 1);
        @(negedge clk);
        chk("on ready back", o_rdy, 1);

        // BLINK pulsed while CONFIG is busy is ignored, then issued normally.
        run(0, 2'd3, 3'b111, 16'd11, 16'd12, 16'd13, 4);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            idle_check("pulse ignored");
        end
        run(0, 2'd2, 3'b000, 16'd0, 16'd0, 16'd0, 0);

        // Reset in the middle of a CONFIG sequence.
        sel = 0;
        @(posedge clk); #1 op = 2'd3; mask = 3'b111; g = 16'd1; r = 16'd2; y = 16'd3; va = 1'b1;
        @(posedge clk); #1 va = 1'b0;
        @(negedge clk);
        chk("pre-reset first cmd", o_vld, 1);
        @(posedge clk); @(posedge clk); #1 srst_n = 1'b0;
        @(posedge clk); #1 srst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            idle_check("after abort");
        end

        for (int i = 0; i < 24; i++) begin
            logic [15:0] rg, rr2, ry;
            rg  = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
            rr2 = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
            ry  = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
            run(1'($urandom), 2'($urandom), 3'($urandom), rg, rr2, ry, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
